// File: rtl/status_led_ctrl.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// status_led_ctrl
//
// Multi-channel status LED sequencer. Every channel is independently set to
// off, on, blink, or "code" mode. In code mode the channel repeats a burst of
// N pulses followed by a long gap, so a board LED can report a numeric status
// or fault. A single shared prescaler produces a one-cycle tick enable. All
// timing counts ticks, so the block runs entirely on clk with no derived
// clocks.
//
// Ports:
//   clk   in   1              system clock, single domain
//   rstn  in   1              synchronous active-low reset
//   mode  in   2*NUM_CH       per-channel mode, ch i at [2i+1:2i]
//                             0 off, 1 on, 2 blink, 3 code
//   code  in   CODE_W*NUM_CH  per-channel pulse count for code mode,
//                             ch i at [CODE_W*i +: CODE_W]
//   tick  out  1              registered one-cycle prescaler strobe
//   led   out  NUM_CH         registered LED drive, 1 = lit
// -----------------------------------------------------------------------------
module status_led_ctrl #(
    parameter int unsigned NUM_CH     = 2,
    parameter int unsigned TICK_DIV   = 65536,
    parameter int unsigned BLINK_HALF = 128,
    parameter int unsigned ON_TICKS   = 32,
    parameter int unsigned OFF_TICKS  = 32,
    parameter int unsigned GAP_TICKS  = 256,
    parameter int unsigned CODE_W     = 4
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic [2*NUM_CH-1:0]        mode,
    input  logic [CODE_W*NUM_CH-1:0]   code,
    output logic                       tick,
    output logic [NUM_CH-1:0]          led
);

    // -------------------------------------------------------------------------
    // Types and derived sizes
    // -------------------------------------------------------------------------
    typedef enum logic [1:0] {
        MODE_OFF   = 2'd0,
        MODE_ON    = 2'd1,
        MODE_BLINK = 2'd2,
        MODE_CODE  = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_PULSE_ON  = 2'd1,
        S_PULSE_OFF = 2'd2,
        S_GAP       = 2'd3
    } code_state_e;

    localparam int unsigned PRE_W        = $clog2(TICK_DIV);
    localparam int unsigned BLINK_PERIOD = 2 * BLINK_HALF;
    localparam int unsigned BLINK_W      = $clog2(BLINK_PERIOD);

    // The channel timer is shared by all three timed states, so it is sized
    // for the longest of them. A width floor of 1 keeps the degenerate case
    // where every duration is a single tick legal.
    localparam int unsigned MAX_TICKS_OO = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
    localparam int unsigned MAX_TICKS    = (MAX_TICKS_OO > GAP_TICKS) ? MAX_TICKS_OO : GAP_TICKS;
    localparam int unsigned TMR_W        = (MAX_TICKS > 1) ? $clog2(MAX_TICKS) : 1;

    localparam logic [PRE_W-1:0]   PRE_LAST    = PRE_W'(TICK_DIV - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST  = BLINK_W'(BLINK_PERIOD - 1);
    localparam logic [BLINK_W-1:0] BLINK_HALF_V = BLINK_W'(BLINK_HALF);
    localparam logic [TMR_W-1:0]   ON_LAST     = TMR_W'(ON_TICKS - 1);
    localparam logic [TMR_W-1:0]   OFF_LAST    = TMR_W'(OFF_TICKS - 1);
    localparam logic [TMR_W-1:0]   GAP_LAST    = TMR_W'(GAP_TICKS - 1);

    // -------------------------------------------------------------------------
    // Shared prescaler
    // -------------------------------------------------------------------------
    logic [PRE_W-1:0] pre_cnt_q, pre_cnt_d;
    logic             tick_q, tick_d;

    // NOTE: every variable written in an always_comb gets a default first, so
    // no path can leave it unassigned and infer a latch.
    always_comb begin
        pre_cnt_d = pre_cnt_q + PRE_W'(1);
        if (pre_cnt_q == PRE_LAST) begin
            pre_cnt_d = '0;
        end
    end

    // The strobe is registered from the terminal count, so it appears in the
    // cycle after the counter reaches TICK_DIV-1.
    assign tick_d = (pre_cnt_q == PRE_LAST);

    // NOTE: state registers use non-blocking assignments so all flops sample
    // their inputs at the same edge regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            pre_cnt_q <= '0;
            tick_q    <= 1'b0;
        end else begin
            pre_cnt_q <= pre_cnt_d;
            tick_q    <= tick_d;
        end
    end

    assign tick = tick_q;

    // -------------------------------------------------------------------------
    // Shared blink counter: one counter keeps all blinking channels in phase.
    // -------------------------------------------------------------------------
    logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
    logic               blink_phase_d;

    always_comb begin
        blink_cnt_d = blink_cnt_q;
        if (tick_q) begin
            if (blink_cnt_q == BLINK_LAST) begin
                blink_cnt_d = '0;
            end else begin
                blink_cnt_d = blink_cnt_q + BLINK_W'(1);
            end
        end
    end

    // Decoded from the next count so the LED register changes on the same
    // edge as the counter itself.
    assign blink_phase_d = (blink_cnt_d < BLINK_HALF_V);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            blink_cnt_q <= '0;
        end else begin
            blink_cnt_q <= blink_cnt_d;
        end
    end

    // -------------------------------------------------------------------------
    // Per-channel code FSM and LED register
    // -------------------------------------------------------------------------
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        mode_e             ch_mode;
        logic [CODE_W-1:0] ch_code;
        logic              code_req;
        code_state_e       state_q, state_d;
        logic [TMR_W-1:0]  timer_q, timer_d;
        logic [CODE_W-1:0] remain_q, remain_d;
        logic              led_q, led_d;

        assign ch_mode  = mode_e'(mode[2*i +: 2]);
        assign ch_code  = code[CODE_W*i +: CODE_W];
        // A zero count in code mode is treated as "nothing to report".
        assign code_req = (ch_mode == MODE_CODE) && (ch_code != '0);

        always_comb begin
            state_d  = state_q;
            timer_d  = timer_q;
            remain_d = remain_q;

            if (ch_mode != MODE_CODE) begin
                // Leaving code mode aborts the sequence on any cycle, not
                // just on a tick, so a later return always starts cleanly.
                state_d = S_IDLE;
                timer_d = '0;
            end else if (tick_q) begin
                case (state_q)
                    S_IDLE: begin
                        if (code_req) begin
                            remain_d = ch_code;
                            timer_d  = '0;
                            state_d  = S_PULSE_ON;
                        end
                    end

                    S_PULSE_ON: begin
                        if (timer_q == ON_LAST) begin
                            timer_d = '0;
                            if (remain_q == CODE_W'(1)) begin
                                state_d = S_GAP;
                            end else begin
                                remain_d = remain_q - CODE_W'(1);
                                state_d  = S_PULSE_OFF;
                            end
                        end else begin
                            timer_d = timer_q + TMR_W'(1);
                        end
                    end

                    S_PULSE_OFF: begin
                        if (timer_q == OFF_LAST) begin
                            timer_d = '0;
                            state_d = S_PULSE_ON;
                        end else begin
                            timer_d = timer_q + TMR_W'(1);
                        end
                    end

                    S_GAP: begin
                        if (timer_q == GAP_LAST) begin
                            timer_d = '0;
                            // The code input is sampled only here and in
                            // IDLE, so changes mid-burst take effect on the
                            // following burst.
                            if (code_req) begin
                                remain_d = ch_code;
                                state_d  = S_PULSE_ON;
                            end else begin
                                state_d = S_IDLE;
                            end
                        end else begin
                            timer_d = timer_q + TMR_W'(1);
                        end
                    end

                    default: begin
                        state_d = S_IDLE;
                        timer_d = '0;
                    end
                endcase
            end
        end

        // LED decode from next state, so the output edge lines up with the
        // state change rather than trailing it by a cycle.
        always_comb begin
            led_d = 1'b0;
            case (ch_mode)
                MODE_OFF:   led_d = 1'b0;
                MODE_ON:    led_d = 1'b1;
                MODE_BLINK: led_d = blink_phase_d;
                MODE_CODE:  led_d = (state_d == S_PULSE_ON);
                default:    led_d = 1'b0;
            endcase
        end

        always_ff @(posedge clk) begin
            if (!rstn) begin
                state_q  <= S_IDLE;
                timer_q  <= '0;
                remain_q <= '0;
                led_q    <= 1'b0;
            end else begin
                state_q  <= state_d;
                timer_q  <= timer_d;
                remain_q <= remain_d;
                led_q    <= led_d;
            end
        end

        assign led[i] = led_q;
    end

endmodule

// File: doc/status_led_ctrl.md
Name: status_led_ctrl

Overview:
Multi-channel status LED sequencer that generalises the single free-running heartbeat into NUM_CH independently moded LED outputs. Each channel can be off, on, blinking, or emitting a repeating N-pulse fault/status code. A single shared prescaler generates a tick clock-enable, so the block has no derived clocks. It sits at top level, driven by system/fault status, and drives board LEDs.

Parameters:
NUM_CH, 2, number of LED channels
TICK_DIV, 65536, clk cycles per tick (>=2)
BLINK_HALF, 128, ticks per blink half-period
ON_TICKS, 32, ticks per code pulse high
OFF_TICKS, 32, ticks low between code pulses
GAP_TICKS, 256, ticks low after last pulse of a code sequence
CODE_W, 4, width of per-channel pulse count

Ports:
clk  in  1  system clock; single clock domain
rstn  in  1  synchronous, active-low reset
mode  in  2*NUM_CH  per-channel mode, ch i at [2i+1:2i]: 0 off, 1 on, 2 blink, 3 code
code  in  CODE_W*NUM_CH  per-channel pulse count for mode 3, ch i at [CODE_W*i +: CODE_W]
tick  out  1  one-cycle prescaler strobe
led  out  NUM_CH  registered LED drive, 1 = lit

Behaviour:
- Reset (rstn low at a clk edge, any time incl. mid-sequence): prescaler, blink counter, all channel FSMs/timers cleared; led = 0, tick = 0; every channel FSM in IDLE.
- Prescaler: counts 0..TICK_DIV-1, width $clog2(TICK_DIV), wraps to 0. tick registered, high for exactly one cycle when count == TICK_DIV-1. First tick is the TICK_DIV-th cycle after reset release. Free-running, independent of mode.
- Blink counter: shared, advances on tick, counts 0..2*BLINK_HALF-1, wraps. blink_phase = (cnt < BLINK_HALF). All mode-2 channels are in phase.
- led is a register updated every clk from next-state decode: mode 0 -> 0; mode 1 -> 1; mode 2 -> blink_phase; mode 3 -> 1 only in PULSE_ON. Mode 0/1/2 changes reach led one cycle later.
- Code FSM per channel: states IDLE, PULSE_ON, PULSE_OFF, GAP; per-channel tick timer and remaining-pulse counter (CODE_W bits).
  - IDLE: on tick, if mode==3 and code!=0 -> latch code into remain, timer=0, go PULSE_ON.
  - PULSE_ON: count ticks; after ON_TICKS ticks: if remain==1 -> GAP, else remain-1 -> PULSE_OFF.
  - PULSE_OFF: after OFF_TICKS ticks -> PULSE_ON.
  - GAP: after GAP_TICKS ticks: if mode==3 and code!=0 -> relatch code, go directly to PULSE_ON; else IDLE.
  - State transitions occur only on tick cycles, except abort.
  - Abort: any cycle with mode!=3 forces IDLE and timer=0 at the next edge.
- code changes mid-sequence are ignored until the next latch (IDLE start or GAP end). code==0 in mode 3 keeps channel in IDLE, led 0.
- Channels are fully independent apart from the shared tick and blink counter.
- Timer widths are sized by $clog2 of the largest of ON/OFF/GAP_TICKS. No counter may overflow for any legal parameter set.

Test Plan:
1. Params TICK_DIV=4, BLINK_HALF=2, ON_TICKS=2, OFF_TICKS=1, GAP_TICKS=4, NUM_CH=2 for all scenarios. Reset held 3 cycles during an active code pulse -> led=00, tick=0; after release tick first high on cycle 4, then every 4 cycles.
2. mode ch0=1 then 0 -> led[0] rises 1 cycle after mode=1 and falls 1 cycle after mode=0; led[1] unaffected.
3. Both channels mode=2 from reset -> each led high 8 cycles, low 8 cycles (period 16), both edges identical on both channels.
4. ch0 mode=3, code=3 -> three 8-cycle high pulses separated by 4-cycle lows, then 16 cycles low, repeat. Changing code to 1 during the second pulse -> current sequence still gives 3 pulses, next sequence gives 1.
5. ch0 mode 3->0 mid PULSE_ON -> led[0]=0 next cycle. Back to 3 with code=2 -> first pulse starts on the next tick and lasts 8 cycles.
6. ch1 mode=3, code=0 for 64 cycles -> led[1] stays 0; code=1 -> single 8-cycle pulse then 16-cycle gap, repeating.
